// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the fixed point facility hazard tracking.
// StageEntry describes one in-flight instruction between EXE and WB.
// The HAZARD_BYPASS_EN macro is consumed by hazard_scoreboard, not here.
package pipeline_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int PIPE_STAGES = 3;
  localparam int FWD_W       = $clog2(PIPE_STAGES + 1);

  typedef struct packed {
    logic                  wen;
    logic [REG_ADDR_W-1:0] addr;
    logic                  is_load;
  } StageEntry;

  // Forward select for the default depth: 0 = regfile, k = stage k-1.
  typedef logic [FWD_W-1:0] FwdSel;

  localparam StageEntry BUBBLE = StageEntry'('0);

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Per-read-port match against every tracked stage.
// Reports the youngest (lowest index) matching stage, whether any stage
// matched, and whether that youngest match is a load not yet forwardable.
module hazard_match
  import pipeline_pkg::*;
#(
  parameter int NUM_STAGES = PIPE_STAGES,
  parameter int LOAD_STAGE = 1,
  parameter int IDX_W      = FWD_W
) (
  input  StageEntry             st [NUM_STAGES],
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic                  oen,
  output logic [IDX_W-1:0]      match_idx,
  output logic                  hit,
  output logic                  load_pending
);

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    match_idx    = '0;
    hit          = 1'b0;
    load_pending = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (oen && st[i].wen && (st[i].addr == rs_addr)) begin
        match_idx    = IDX_W'(i);
        hit          = 1'b1;
        load_pending = st[i].is_load && (i < LOAD_STAGE);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW-hazard scoreboard: tracks in-flight destinations from EXE to WB,
// raises the decode stall and, when built with HAZARD_BYPASS_EN, drives
// per-port forward selects so only not-yet-available load data stalls.
// Without HAZARD_BYPASS_EN any match stalls and fwd_sel is tied to 0.
module hazard_scoreboard
  import pipeline_pkg::*;
#(
  parameter int NUM_STAGES = PIPE_STAGES,
  parameter int NUM_RS     = 3,
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int LOAD_STAGE = 1,
  parameter int CNT_W      = 16
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      dec_valid,
  input  logic [NUM_RS*ADDR_W-1:0]                  dec_rs_addr,
  input  logic [NUM_RS-1:0]                         dec_rs_oen,
  input  logic [ADDR_W-1:0]                         dec_wb_addr,
  input  logic                                      dec_rf_wen,
  input  logic                                      dec_is_load,
  input  logic                                      dec_kill,
  input  logic                                      cmiss_stall,
  output logic                                      hazard_stall,
  output logic [NUM_RS*$clog2(NUM_STAGES+1)-1:0]    fwd_sel,
  output logic                                      wb_rf_wen,
  output logic [ADDR_W-1:0]                         wb_wb_addr,
  output logic [CNT_W-1:0]                          stall_cnt
);

  localparam int SEL_W = $clog2(NUM_STAGES + 1);

  StageEntry          st [NUM_STAGES];
  logic [NUM_RS-1:0]  port_hit;
  logic [NUM_RS-1:0]  port_load;
  logic [NUM_RS-1:0]  port_stall;
  logic [SEL_W-1:0]   port_idx [NUM_RS];
  logic               raw;
  logic [CNT_W-1:0]   stall_cnt_q;

  genvar p;
  generate
    for (p = 0; p < NUM_RS; p++) begin : g_port
      hazard_match #(
        .NUM_STAGES (NUM_STAGES),
        .LOAD_STAGE (LOAD_STAGE),
        .IDX_W      (SEL_W)
      ) u_match (
        .st           (st),
        .rs_addr      (dec_rs_addr[p*ADDR_W +: ADDR_W]),
        .oen          (dec_rs_oen[p]),
        .match_idx    (port_idx[p]),
        .hit          (port_hit[p]),
        .load_pending (port_load[p])
      );
`ifdef HAZARD_BYPASS_EN
      // Only a load still short of its forwarding stage has to wait.
      assign port_stall[p] = port_load[p];
      assign fwd_sel[p*SEL_W +: SEL_W] =
        (port_hit[p] && !port_load[p]) ? port_idx[p] + SEL_W'(1) : '0;
`else
      // No bypass network: any in-flight writer blocks the read.
      logic unused_sel;
      assign unused_sel = ^{port_idx[p], port_load[p]};
      assign port_stall[p] = port_hit[p];
      assign fwd_sel[p*SEL_W +: SEL_W] = '0;
`endif
    end
  endgenerate

  // A killed decode slot never stalls; it is replaced by a bubble instead.
  assign raw          = |port_stall;
  assign hazard_stall = raw & dec_valid & ~dec_kill;

  assign wb_rf_wen  = st[NUM_STAGES-1].wen;
  assign wb_wb_addr = st[NUM_STAGES-1].addr;
  assign stall_cnt  = stall_cnt_q;

  // Advance the stage array unless the whole pipe is frozen by a cache miss.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_STAGES; i++) st[i] <= BUBBLE;
    end else if (!cmiss_stall) begin
      for (int i = NUM_STAGES - 1; i > 0; i--) st[i] <= st[i-1];
      if (dec_kill || hazard_stall || !dec_valid) begin
        st[0] <= BUBBLE;
      end else begin
        st[0].wen     <= dec_rf_wen;
        st[0].addr    <= dec_wb_addr;
        st[0].is_load <= dec_is_load & dec_rf_wen;
      end
    end
  end

  // Saturating count of stall cycles that actually cost a decode slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (hazard_stall && !cmiss_stall && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

endmodule
